// File: rtl/ble_rx_dma.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ble_rx_dma                                                               |
// | Buffers UART receive bytes in a FIFO and writes them into a RAM ring     |
// | window as a Wishbone master, yielding to the CPU bus. Optional macro     |
// | BLE_RX_DMA_CNT_EN builds the committed-byte counter on o_byte_cnt.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ble_rx_dma #(
    parameter int          DEPTH  = 8,
    parameter logic [31:0] ADR_LL = 32'h00C00000,
    parameter logic [31:0] ADR_UL = 32'h00C00FFF
) (
    input  logic                     i_wb_clk,
    input  logic                     i_wb_rst_n,
    input  logic [7:0]               i_rx_dat,
    input  logic                     i_rx_done,
    input  logic                     i_cpu_cyc,
    output logic                     o_wb_cyc,
    output logic                     o_wb_we,
    output logic [31:0]              o_wb_adr,
    output logic [3:0]               o_wb_sel,
    output logic [31:0]              o_wb_dat,
    input  logic                     i_wb_ack,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    input  logic                     i_ovf_clr,
    output logic [31:0]              o_byte_cnt
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_XFER = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;
    logic            r_overflow;
    logic [31:0]     r_adr;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    assign w_full = (r_level == c_LW'(DEPTH));
    assign w_pop  = (r_state == c_ST_XFER) && i_wb_ack;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push = i_rx_done && (!w_full || w_pop);
    assign w_drop = i_rx_done && w_full && !w_pop;

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (r_level != '0 && !i_cpu_cyc) w_state_nxt = c_ST_XFER;
            c_ST_XFER: if (i_wb_ack) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Storage is cleared on reset so the idle data bus reads zero.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_rx_dat;
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            r_adr <= ADR_LL;
        end else if (w_pop) begin
            r_adr <= (r_adr == ADR_UL) ? ADR_LL : r_adr + 32'd1;
        end
    end

`ifdef BLE_RX_DMA_CNT_EN
    logic [31:0] r_byte_cnt;

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            r_byte_cnt <= 32'h0;
        end else if (w_pop) begin
            r_byte_cnt <= r_byte_cnt + 32'd1;
        end
    end

    assign o_byte_cnt = r_byte_cnt;
`else
    assign o_byte_cnt = 32'h0;
`endif

    assign o_wb_cyc   = (r_state == c_ST_XFER);
    assign o_wb_we    = o_wb_cyc;
    assign o_wb_adr   = r_adr;
    assign o_wb_sel   = 4'b0001 << r_adr[1:0];
    assign o_wb_dat   = {4{r_mem[r_rd_ptr]}};
    assign o_level    = r_level;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ble_rx_dma.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ble_rx_dma                                                            |
// | Directed bench for ble_rx_dma: a default-window instance and a 4-byte    |
// | ring instance share the stimulus; each has a one-cycle-ack RAM model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ble_rx_dma;

    localparam logic [31:0] c_LL = 32'h00C00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_dat = 8'h00;
    logic        rx_done = 1'b0;
    logic        cpu_cyc = 1'b0;
    logic        ovf_clr = 1'b0;

    logic        cyc_a, we_a, ack_a, ovf_a;
    logic [31:0] adr_a, dat_a, cnt_a;
    logic [3:0]  sel_a;
    logic [3:0]  lvl_a;
    logic        cyc_b, we_b, ack_b, ovf_b;
    logic [31:0] adr_b, dat_b, cnt_b;
    logic [3:0]  sel_b;
    logic [3:0]  lvl_b;

    logic [31:0] log_adr_a[$];
    logic [3:0]  log_sel_a[$];
    logic [7:0]  log_dat_a[$];
    logic [31:0] log_adr_b[$];
    logic [31:0] ram_a [0:1023];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ble_rx_dma #(.DEPTH(8), .ADR_LL(c_LL), .ADR_UL(32'h00C00FFF)) u_dut_a (
        .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_rx_dat(rx_dat), .i_rx_done(rx_done),
        .i_cpu_cyc(cpu_cyc), .o_wb_cyc(cyc_a), .o_wb_we(we_a), .o_wb_adr(adr_a),
        .o_wb_sel(sel_a), .o_wb_dat(dat_a), .i_wb_ack(ack_a), .o_level(lvl_a),
        .o_overflow(ovf_a), .i_ovf_clr(ovf_clr), .o_byte_cnt(cnt_a)
    );

    ble_rx_dma #(.DEPTH(8), .ADR_LL(c_LL), .ADR_UL(32'h00C00003)) u_dut_b (
        .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_rx_dat(rx_dat), .i_rx_done(rx_done),
        .i_cpu_cyc(cpu_cyc), .o_wb_cyc(cyc_b), .o_wb_we(we_b), .o_wb_adr(adr_b),
        .o_wb_sel(sel_b), .o_wb_dat(dat_b), .i_wb_ack(ack_b), .o_level(lvl_b),
        .o_overflow(ovf_b), .i_ovf_clr(ovf_clr), .o_byte_cnt(cnt_b)
    );

    // RAM models: ack one cycle after cyc, log each committed write.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_a <= 1'b0;
        end else begin
            ack_a <= cyc_a && !ack_a;
            if (cyc_a && ack_a) begin
                log_adr_a.push_back(adr_a);
                log_sel_a.push_back(sel_a);
                log_dat_a.push_back(dat_a[7:0]);
                for (int l = 0; l < 4; l++)
                    if (sel_a[l]) ram_a[adr_a[11:2]][8*l +: 8] = dat_a[8*l +: 8];
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_b <= 1'b0;
        end else begin
            ack_b <= cyc_b && !ack_b;
            if (cyc_b && ack_b) log_adr_b.push_back(adr_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        log_adr_a.delete(); log_sel_a.delete(); log_dat_a.delete(); log_adr_b.delete();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b, input logic clr);
        rx_dat  = b;
        rx_done = 1'b1;
        ovf_clr = clr;
        @(negedge clk);
        rx_done = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((lvl_a != 0 || cyc_a || lvl_b != 0 || cyc_b) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 200), 32'd1);
    endtask

    initial begin
        logic seen_cyc;
        int   n;
        for (int i = 0; i < 1024; i++) ram_a[i] = 32'h0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_cyc", 32'(cyc_a), 32'd0);
        check("rst_we", 32'(we_a), 32'd0);
        check("rst_adr", adr_a, c_LL);
        check("rst_sel", 32'(sel_a), 32'h1);
        check("rst_dat", dat_a, 32'h0);
        check("rst_lvl", 32'(lvl_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_cnt", cnt_a, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte latency
        push(8'hA5, 1'b0);
        check("one_lvl", 32'(lvl_a), 32'd1);
        check("one_cyc0", 32'(cyc_a), 32'd0);
        @(negedge clk);
        check("one_cyc1", 32'(cyc_a), 32'd1);
        check("one_we", 32'(we_a), 32'd1);
        check("one_adr", adr_a, 32'h00C00000);
        check("one_sel", 32'(sel_a), 32'h1);
        check("one_dat", dat_a, 32'hA5A5A5A5);
        @(negedge clk);
        check("one_hold", dat_a, 32'hA5A5A5A5);
        check("one_nolog", 32'(log_adr_a.size()), 32'd0);
        @(negedge clk);
        check("one_commit", 32'(log_adr_a.size()), 32'd1);
        check("one_lvl0", 32'(lvl_a), 32'd0);
        check("one_cycoff", 32'(cyc_a), 32'd0);
`ifdef BLE_RX_DMA_CNT_EN
        check("one_cnt", cnt_a, 32'd1);
`else
        check("one_cnt", cnt_a, 32'd0);
`endif

        // Lane walk
        do_reset();
        for (int i = 1; i <= 5; i++) push(8'(i), 1'b0);
        wait_idle("walk_timeout");
        check("walk_n", 32'(log_adr_a.size()), 32'd5);
        check("walk_adr0", log_adr_a[0], 32'h00C00000);
        check("walk_adr4", log_adr_a[4], 32'h00C00004);
        check("walk_sel0", 32'(log_sel_a[0]), 32'b0001);
        check("walk_sel1", 32'(log_sel_a[1]), 32'b0010);
        check("walk_sel2", 32'(log_sel_a[2]), 32'b0100);
        check("walk_sel3", 32'(log_sel_a[3]), 32'b1000);
        check("walk_sel4", 32'(log_sel_a[4]), 32'b0001);
        check("walk_word0", ram_a[0], 32'h04030201);
        check("walk_word1", ram_a[1], 32'h00000005);

        // Wrap on the 4-byte ring instance
        do_reset();
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i), 1'b0);
        wait_idle("wrap_timeout");
        check("wrap_n", 32'(log_adr_b.size()), 32'd6);
        check("wrap_adr3", log_adr_b[3], 32'h00C00003);
        check("wrap_adr4", log_adr_b[4], 32'h00C00000);
        check("wrap_adr5", log_adr_b[5], 32'h00C00001);
        check("wrap_ptr", adr_b, 32'h00C00002);

        // CPU contention and overflow
        do_reset();
        cpu_cyc  = 1'b1;
        seen_cyc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push(8'h10 + 8'(i), 1'b0);
            seen_cyc = seen_cyc | cyc_a;
        end
        check("hog_nocyc", 32'(seen_cyc), 32'd0);
        check("hog_lvl", 32'(lvl_a), 32'd8);
        check("hog_ovf", 32'(ovf_a), 32'd1);
        cpu_cyc = 1'b0;
        wait_idle("hog_timeout");
        check("hog_n", 32'(log_dat_a.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("hog_order", 32'(log_dat_a[i]), 32'h10 + 32'(i));
            check("hog_adr", log_adr_a[i], c_LL + 32'(i));
        end
        check("ovf_sticky", 32'(ovf_a), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(ovf_a), 32'd0);
        cpu_cyc = 1'b1;
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i), 1'b0);
        check("refill_lvl", 32'(lvl_a), 32'd8);
        push(8'h28, 1'b1);
        check("ovf_setwins", 32'(ovf_a), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clr2", 32'(ovf_a), 32'd0);

        // Push while full coincides with the acked pop
        cpu_cyc = 1'b0;
        n = 0;
        while (!ack_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("full_ack_seen", 32'(ack_a), 32'd1);
        check("full_lvl_pre", 32'(lvl_a), 32'd8);
        push(8'h29, 1'b0);
        check("full_lvl", 32'(lvl_a), 32'd8);
        check("full_ovf", 32'(ovf_a), 32'd0);
        wait_idle("full_timeout");
        check("full_n", 32'(log_dat_a.size()), 32'd17);
        check("full_first", 32'(log_dat_a[8]), 32'h20);
        check("full_last", 32'(log_dat_a[16]), 32'h29);

        // Reset in the middle of a transfer
        push(8'h77, 1'b0);
        n = 0;
        while (!cyc_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_cyc", 32'(cyc_a), 32'd1);
`ifdef BLE_RX_DMA_CNT_EN
        check("mid_cnt_pre", cnt_a, 32'd17);
`else
        check("mid_cnt_pre", cnt_a, 32'd0);
`endif
        rst_n = 1'b0;
        #1;
        check("mid_cyc0", 32'(cyc_a), 32'd0);
        check("mid_lvl", 32'(lvl_a), 32'd0);
        check("mid_adr", adr_a, c_LL);
        check("mid_cnt", cnt_a, 32'h0);
        check("mid_dat", dat_a, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_nocommit", 32'(log_dat_a.size()), 32'd17);
        check("mid_idle", 32'(cyc_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
